// File: rtl/vga_scanout_pkg.sv
// Shared 640x480@60 timing constants and control-bundle type for the scanout path and
// graphics_processor.
package vga_scanout_pkg;

  localparam int unsigned HVisible    = 640;
  localparam int unsigned HFrontPorch = 16;
  localparam int unsigned HSyncWidth  = 96;
  localparam int unsigned HBackPorch  = 48;
  localparam int unsigned HTotal      = HVisible + HFrontPorch + HSyncWidth + HBackPorch;

  localparam int unsigned VVisible    = 480;
  localparam int unsigned VFrontPorch = 10;
  localparam int unsigned VSyncWidth  = 2;
  localparam int unsigned VBackPorch  = 33;
  localparam int unsigned VTotal      = VVisible + VFrontPorch + VSyncWidth + VBackPorch;

  localparam int unsigned AddrW  = 19;
  localparam int unsigned ColorW = 12;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic vblank;
    logic frame_start;
  } vga_ctrl_t;

  localparam vga_ctrl_t CtrlIdle = '{
    hsync:       1'b1,
    vsync:       1'b1,
    de:          1'b0,
    vblank:      1'b0,
    frame_start: 1'b0
  };

endpackage

// File: rtl/vga_timing.sv
// Free-running h/v raster counters with raw (undelayed) sync, display-enable, vblank and
// frame-start decode. Counters sit at (0,0) while en is low.
module vga_timing
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VISIBLE = HVisible,
  parameter int unsigned V_VISIBLE = VVisible
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  output vga_ctrl_t ctrl
);

  // Porch and sync widths are fixed; only the visible area scales.
  localparam int unsigned HTot = H_VISIBLE + HFrontPorch + HSyncWidth + HBackPorch;
  localparam int unsigned VTot = V_VISIBLE + VFrontPorch + VSyncWidth + VBackPorch;
  localparam int unsigned HW   = $clog2(HTot);
  localparam int unsigned VW   = $clog2(VTot);

  localparam logic [HW-1:0] HLast      = HW'(HTot - 1);
  localparam logic [HW-1:0] HVisEnd    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HSyncStart = HW'(H_VISIBLE + HFrontPorch);
  localparam logic [HW-1:0] HSyncEnd   = HW'(H_VISIBLE + HFrontPorch + HSyncWidth);
  localparam logic [VW-1:0] VLast      = VW'(VTot - 1);
  localparam logic [VW-1:0] VVisEnd    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VSyncStart = VW'(V_VISIBLE + VFrontPorch);
  localparam logic [VW-1:0] VSyncEnd   = VW'(V_VISIBLE + VFrontPorch + VSyncWidth);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + VW'(1);
    end
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    ctrl = CtrlIdle;
    if (en) begin
      ctrl.de          = (h_q < HVisEnd) && (v_q < VVisEnd);
      ctrl.hsync       = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
      ctrl.vsync       = !((v_q >= VSyncStart) && (v_q < VSyncEnd));
      ctrl.vblank      = (v_q >= VVisEnd);
      ctrl.frame_start = (h_q == '0) && (v_q == '0);
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: linear VRAM address counter plus a three-stage alignment pipeline so that
// rgb and all control outputs describe the same raster position.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VISIBLE = HVisible,
  parameter int unsigned V_VISIBLE = VVisible
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [AddrW-1:0]  vram_raddr,
  input  logic [ColorW-1:0] vram_rdata,
  output logic [ColorW-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              vblank,
  output logic              frame_start
);

  localparam logic [AddrW-1:0] AddrLast = AddrW'(H_VISIBLE * V_VISIBLE - 1);

  vga_ctrl_t         ctrl_raw;
  vga_ctrl_t         ctrl_s1_q, ctrl_s2_q, ctrl_s3_q;
  logic [AddrW-1:0]  pix_addr_q, pix_addr_d;
  logic [AddrW-1:0]  raddr_q, raddr_d;
  logic [ColorW-1:0] rgb_q, rgb_d;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE),
    .V_VISIBLE(V_VISIBLE)
  ) u_timing (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .ctrl (ctrl_raw)
  );

  // Address advances only on visible pixels, so it wraps to 0 exactly at the frame end
  // and the issued address holds through blanking.
  always_comb begin
    pix_addr_d = pix_addr_q;
    raddr_d    = raddr_q;
    if (ctrl_raw.de) begin
      raddr_d    = pix_addr_q;
      pix_addr_d = (pix_addr_q == AddrLast) ? '0 : pix_addr_q + AddrW'(1);
    end
    rgb_d = ctrl_s2_q.de ? vram_rdata : '0;
  end

  // Disable flushes the pipeline rather than draining it.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      pix_addr_q <= '0;
      raddr_q    <= '0;
      ctrl_s1_q  <= CtrlIdle;
      ctrl_s2_q  <= CtrlIdle;
      ctrl_s3_q  <= CtrlIdle;
      rgb_q      <= '0;
    end else begin
      pix_addr_q <= pix_addr_d;
      raddr_q    <= raddr_d;
      ctrl_s1_q  <= ctrl_raw;
      ctrl_s2_q  <= ctrl_s1_q;
      ctrl_s3_q  <= ctrl_s2_q;
      rgb_q      <= rgb_d;
    end
  end

  assign vram_raddr  = raddr_q;
  assign rgb         = rgb_q;
  assign hsync       = ctrl_s3_q.hsync;
  assign vsync       = ctrl_s3_q.vsync;
  assign de          = ctrl_s3_q.de;
  assign vblank      = ctrl_s3_q.vblank;
  assign frame_start = ctrl_s3_q.frame_start;

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-003 SHALL have ports: clk  input  1  pixel clock, the single clock, all logic on rising edge.
REQ-004 SHALL have ports: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: en  input  1  scanout enable, level.
REQ-006 SHALL have ports: vram_raddr  output  19  VRAM read address, registered.
REQ-007 SHALL have ports: vram_rdata  input  12  VRAM read data, valid one cycle after vram_raddr.
REQ-008 SHALL have ports: rgb  output  12  pixel colour {r[3:0],g[3:0],b[3:0]}, registered.
REQ-009 SHALL have ports: hsync  output  1  horizontal sync, active-low.
REQ-010 SHALL have ports: vsync  output  1  vertical sync, active-low.
REQ-011 SHALL have ports: de  output  1  display-enable, high on visible pixels.
REQ-012 SHALL have ports: vblank  output  1  high while v counter >= V_VISIBLE; drawing window for graphics_processor.
REQ-013 SHALL have ports: frame_start  output  1  one-cycle pulse when counters enter (0,0).

Function
REQ-014 h counter SHALL count 0..799, then wrap to 0 and advance v counter.
REQ-015 v counter SHALL count 0..524, then wrap to 0.
REQ-016 Horizontal: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-017 Vertical: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-018 Linear address SHALL be kept as an incrementing counter, not a multiply: +1 per visible pixel, unchanged in blanking, 0 at (0,0).
REQ-019 Address SHALL equal v*640+h for every visible (h,v); maximum 307199, then 0.
REQ-020 Pipeline: counters (h,v) in cycle n -> vram_raddr in n+1 -> vram_rdata in n+2 -> rgb, hsync, vsync, de in n+3.
REQ-021 hsync, vsync, de SHALL be delayed three cycles so all outputs describe the same (h,v).
REQ-022 rgb SHALL be 0 whenever the delayed de is low.
REQ-023 vblank and frame_start SHALL use the same three-cycle alignment.
REQ-024 en low SHALL hold counters and address at 0, rgb=0, de=0, hsync=vsync=1, vblank=0, frame_start=0.
REQ-025 en rising SHALL start at (0,0); first frame_start SHALL appear 3 cycles later.
REQ-026 en falling mid-frame SHALL take the en-low state on the next edge; the pipeline SHALL be flushed, not drained.
REQ-027 vram_raddr SHALL hold its last value during blanking; no out-of-range address (>307199) SHALL be issued.

Reset
REQ-028 rst_n low at a clock edge SHALL force the REQ-024 state regardless of en; it has priority over en.
REQ-029 Reset mid-frame SHALL restart at (0,0) after release, with no partial-line output.
REQ-030 vram_raddr reset value SHALL be 0.

Structure
REQ-031 Timing constants (totals, porch and sync bounds, 19-bit address width, 640x480 size) SHALL live in a shared include file, also used by graphics_processor.
REQ-032 A sub-module vga_timing SHALL generate h/v counters, raw sync, de, vblank and frame_start; vga_scanout SHALL add the address counter and the delay pipeline.

Verification
REQ-033 Reset release with en=1, run one frame: 800 cycles per hsync period; hsync low exactly 96 cycles; vsync low exactly 2 lines (1600 cycles); 420000 cycles per frame.
REQ-034 VRAM model returning data = addr[11:0]: at the output pixel (h=5,v=2) rgb=0x505 (1285 mod 4096); de high count per frame=307200.
REQ-035 Address boundary: last visible pixel issues 307199, next issued address is 0 at the next frame; none >307199 seen.
REQ-036 Blanking: at h=640..799, rgb=0 and de=0 even with vram_rdata=0xFFF forced.
REQ-037 Drop en at h=100,v=10: next edge counters=0, hsync=vsync=1, rgb=0; re-raise en -> frame_start 3 cycles later.
REQ-038 rst_n low for 1 cycle at v=300 with en=1: outputs idle; after release, vram_raddr sequence restarts 0,1,2,...
